// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the mux_stream_arb slice.
//   MODE_SEL / MODE_RR : channel-selection mode encodings for mux_stream_arb.
//   sel_width(n)       : width of a channel index for an n-channel mux.
package mux_pkg;

  localparam int MODE_SEL = 0;  // channel chosen by the external sel input
  localparam int MODE_RR  = 1;  // channel chosen by round-robin among valid lanes

  // Channel-index width; never below one bit so sel/out_chan stay legal vectors.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stream_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     [N]    : request vector, one bit per channel
//   last    [SELW] : channel granted most recently; the search starts just after it
//   gnt     [SELW] : first requesting channel found, scanning last+1, last+2, ... mod N
//   gnt_vld        : some channel is requesting (gnt is meaningful)
module rr_pick #(
  parameter int N    = 8,
  parameter int SELW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] gnt,
  output logic            gnt_vld
);

  int unsigned    start;
  int unsigned    pos;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so the highest-priority channel sits at bit 0, pick the lowest set
  // bit, then add the rotation back to recover the real channel index.
  always_comb begin
    start   = (32'(last) + 32'd1) % N;
    dbl     = {req, req};
    rot     = N'(dbl >> start);
    pos     = 0;
    gnt_vld = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_vld && rot[i]) begin
        pos     = i;
        gnt_vld = 1'b1;
      end
    end
    gnt = SELW'((pos + start) % N);
  end

endmodule

// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N:1 stream multiplexer with a registered output stage and a
// valid/ready handshake on every input lane and on the output.
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_data  [N*WIDTH]   : packed lane data, lane i at [i*WIDTH +: WIDTH]
//   in_valid [N]         : per-lane valid
//   in_ready [N]         : per-lane ready, at most one bit high per cycle
//   sel      [SELW]      : lane select, only used when MODE == MODE_SEL
//   out_data [WIDTH]     : registered data of the accepted lane
//   out_chan [SELW]      : index of the lane that produced out_data
//   out_valid            : output register holds a word
//   out_ready            : consumer accepts the word
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int N     = 8,
  parameter  int MODE  = MODE_RR,
  localparam int SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_data_q;
  logic [SELW-1:0]       out_chan_q;
  logic [SELW-1:0]       last_grant_q;

  logic                  load_en;
  logic                  xfer;
  logic                  gnt_vld;
  logic [SELW-1:0]       grant;
  logic [SELW-1:0]       rr_gnt;
  logic                  rr_vld;
  logic [(1<<SELW)-1:0]  valid_ext;
  logic [WIDTH-1:0]      grant_data;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .last    (last_grant_q),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // valid padded to the full sel range so an out-of-range sel reads as idle.
  always_comb begin
    valid_ext         = '0;
    valid_ext[N-1:0]  = in_valid;
  end

  always_comb begin
    if (MODE == MODE_RR) begin
      grant   = rr_gnt;
      gnt_vld = rr_vld;
    end else begin
      grant   = sel;
      gnt_vld = valid_ext[sel];
    end
  end

  // The output register can take a word when empty or being drained this cycle.
  // Reset blocks the transfer so no lane sees ready during the reset cycle.
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = !rst && load_en && gnt_vld;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        in_ready[i] = xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_chan_q  <= grant;
      if (MODE == MODE_RR) begin
        last_grant_q <= grant;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// tb_mux_stream_arb: bench for mux_stream_arb with WIDTH=3, N=8. One instance
// in MODE_SEL (index 0) and one in MODE_RR (index 1) share the stimulus; a
// per-instance scoreboard records every accepted input word and checks it
// against what leaves the output register.
module tb_mux_stream_arb;

  localparam int W  = 3;
  localparam int N  = 8;
  localparam int SW = 3;

  typedef struct {
    int unsigned    chan;
    logic [W-1:0]   data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             out_ready;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [SW-1:0]    sel;

  logic [N-1:0]     ir [2];
  logic             ov [2];
  logic [W-1:0]     od [2];
  logic [SW-1:0]    oc [2];

  logic [W-1:0]     dtab [N];
  int unsigned      vectors     = 0;
  int unsigned      miscompares = 0;
  exp_t             q_sel[$];
  exp_t             q_rr[$];
  int               rr_exp [6] = '{2, 5, 2, 5, 2, 5};

  always #5 clk = ~clk;

  mux_stream_arb #(.WIDTH(W), .N(N), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .sel(sel), .out_data(od[0]), .out_chan(oc[0]),
    .out_valid(ov[0]), .out_ready(out_ready)
  );

  mux_stream_arb #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .sel(sel), .out_data(od[1]), .out_chan(oc[1]),
    .out_valid(ov[1]), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sb_step(input int k);
    exp_t e;
    int   n;
    if (rst) begin
      if (k == 0) q_sel.delete(); else q_rr.delete();
      chk($sformatf("rdy_in_rst%0d", k), 32'(ir[k]), 32'd0);
      return;
    end
    if (ov[k] && out_ready) begin
      n = (k == 0) ? q_sel.size() : q_rr.size();
      chk($sformatf("sb_avail%0d", k), 32'(n != 0), 32'd1);
      if (n != 0) begin
        e = (k == 0) ? q_sel.pop_front() : q_rr.pop_front();
        chk($sformatf("sb_data%0d", k), 32'(od[k]), 32'(e.data));
        chk($sformatf("sb_chan%0d", k), 32'(oc[k]), e.chan);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && ir[k][i]) begin
        e.chan = i;
        e.data = dtab[i];
        if (k == 0) q_sel.push_back(e); else q_rr.push_back(e);
      end
    end
    chk($sformatf("rdy_onehot%0d", k), 32'($countones(ir[k]) <= 1), 32'd1);
  endtask

  always @(negedge clk) begin
    sb_step(0);
    sb_step(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dtab[i]             = W'((i + 1) % N);
      in_data[i*W +: W]   = W'((i + 1) % N);
    end
    rst = 1'b1; in_valid = '1; out_ready = 1'b1; sel = '0;

    // reset state, with every lane valid
    cyc(); cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_data%0d", k),  32'(od[k]), 32'd0);
      chk($sformatf("rst_chan%0d", k),  32'(oc[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(ir[k]), 32'd0);
    end
    cyc(); rst = 1'b0;

    // MODE_SEL sweep
    for (int s = 0; s <= 8; s++) begin
      if (s < 8) sel = SW'(s);
      @(negedge clk);
      if (s < 8) chk("sel_ready", 32'(ir[0]), 32'd1 << s);
      if (s == 0) chk("sel_valid0", 32'(ov[0]), 32'd0);
      else begin
        chk("sel_valid", 32'(ov[0]), 32'd1);
        chk("sel_data",  32'(od[0]), 32'(dtab[s-1]));
        chk("sel_chan",  32'(oc[0]), 32'(s - 1));
      end
      cyc();
    end

    // MODE_RR, all lanes valid
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16) chk("rr_ready", 32'(ir[1]), 32'd1 << (c % 8));
      if (c == 0) chk("rr_valid0", 32'(ov[1]), 32'd0);
      else begin
        chk("rr_valid", 32'(ov[1]), 32'd1);
        chk("rr_chan",  32'(oc[1]), 32'((c - 1) % 8));
      end
      cyc();
    end

    // MODE_RR, lanes 2 and 5 only; last grant was lane 0
    in_valid = 8'h24;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) chk("rr25_ready", 32'(ir[1]), 32'd1 << rr_exp[c]);
      chk("rr25_chan", 32'(oc[1]), (c == 0) ? 32'd0 : 32'(rr_exp[c-1]));
      cyc();
    end

    // back-pressure on the first word
    rst = 1'b1; cyc(); rst = 1'b0;
    in_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_ready", 32'(ir[1]), 32'd1);
    cyc(); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov[1]), 32'd1);
      chk("bp_data",  32'(od[1]), 32'(dtab[0]));
      chk("bp_chan",  32'(oc[1]), 32'd0);
      chk("bp_ready", 32'(ir[1]), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", 32'(ir[1]), 32'd2);
    chk("bp_resume_chan",  32'(oc[1]), 32'd0);
    cyc();
    @(negedge clk);
    chk("bp_next_chan", 32'(oc[1]), 32'd1);
    chk("bp_next_data", 32'(od[1]), 32'(dtab[1]));
    cyc();

    // reset while holding lane 5's word (110); last grant is lane 2
    in_valid = 8'h20;
    @(negedge clk);
    chk("hold_ready", 32'(ir[1]), 32'h20);
    cyc(); in_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("hold_valid", 32'(ov[1]), 32'd1);
    chk("hold_data",  32'(od[1]), 32'b110);
    chk("hold_chan",  32'(oc[1]), 32'd5);
    cyc(); rst = 1'b1; in_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(ir[1]), 32'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(ov[1]), 32'd0);
    chk("midrst_data",  32'(od[1]), 32'd0);
    chk("midrst_rr0",   32'(ir[1]), 32'd1);
    cyc();
    @(negedge clk);
    chk("midrst_chan", 32'(oc[1]), 32'd0);
    chk("midrst_v1",   32'(ov[1]), 32'd1);
    cyc();

    // MODE_SEL on an idle lane
    sel = 3'd1; in_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("idle_pre_ready", 32'(ir[0]), 32'd2);
    cyc(); sel = 3'd3; in_valid = 8'hF7; out_ready = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(ov[0]), 32'd1);
    chk("idle_data",  32'(od[0]), 32'(dtab[1]));
    chk("idle_ready", 32'(ir[0]), 32'd0);
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready2", 32'(ir[0]), 32'd0);
    chk("idle_valid2", 32'(ov[0]), 32'd1);
    cyc();
    @(negedge clk);
    chk("idle_drop",      32'(ov[0]), 32'd0);
    chk("idle_keep_data", 32'(od[0]), 32'(dtab[1]));
    chk("idle_keep_chan", 32'(oc[0]), 32'd1);
    cyc();

    // drain and confirm nothing accepted was lost
    in_valid = '0; out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("sb_left_sel", 32'(q_sel.size()), 32'd0);
    chk("sb_left_rr",  32'(q_rr.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
